// File: rtl/sys_cmd_controller.sv
// Frame-based command sequencer: RX bytes -> register file / ALU strobes, responses via TX FIFO.
// Optional partial-frame abort is enabled by defining CMD_TIMEOUT_EN.
module sys_cmd_controller #(
    parameter int WIDTH     = 8,
    parameter int ADDR      = 4,
    parameter int FUN_W     = 4,
    parameter int RES_BYTES = 2,
    parameter int TX_DEPTH  = 4,
    parameter int TIMEOUT   = 1023
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [WIDTH-1:0]           rx_data_in,
    input  logic                       rx_data_valid_in,
    input  logic                       tx_busy_in,
    input  logic [WIDTH-1:0]           rf_rd_data_in,
    input  logic                       rf_rd_data_valid_in,
    input  logic [RES_BYTES*WIDTH-1:0] alu_data_in,
    input  logic                       alu_data_valid_in,
    output logic                       rf_wr_en_out,
    output logic                       rf_rd_en_out,
    output logic [ADDR-1:0]            rf_addr_out,
    output logic [WIDTH-1:0]           rf_wr_data_out,
    output logic                       alu_en_out,
    output logic [FUN_W-1:0]           alu_fun_out,
    output logic                       clk_gate_en_out,
    output logic                       clk_div_en_out,
    output logic [WIDTH-1:0]           tx_data_out,
    output logic                       tx_data_valid_out,
    output logic [7:0]                 drop_cnt_out
);
    localparam int PW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int CW = $clog2(TX_DEPTH + 1);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_ISSUE, RD_WAIT,
        ALU_A, ALU_B, ALU_FUN, ALU_ISSUE, ALU_WAIT
    } state_t;
    typedef enum logic [1:0] {DR_IDLE, DR_HI, DR_LO} drain_t;

    state_t state_q, state_d;
    drain_t dr_q, dr_d;

    logic [WIDTH-1:0]           mem [TX_DEPTH];
    logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]              cnt_q, free, push_n;
    logic [RES_BYTES*WIDTH-1:0] push_bytes;
    logic known_cmd, frame_st, wr_go, rd_go, alu_go, alu_go_q, pop, drop, tmo_hit;

    assign free      = CW'(TX_DEPTH) - cnt_q;
    assign known_cmd = rx_data_in == WIDTH'(8'hAA) || rx_data_in == WIDTH'(8'hBB) ||
                       rx_data_in == WIDTH'(8'hCC) || rx_data_in == WIDTH'(8'hDD);
    assign frame_st  = state_q inside {WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN};

`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;
    // counts idle cycles inside a frame; the TIMEOUT-th idle cycle aborts
    assign tmo_hit = frame_st && !rx_data_valid_in && tmo_q == TW'(TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (!reset_n || !frame_st || rx_data_valid_in) tmo_q <= '0;
        else                                           tmo_q <= tmo_q + TW'(1);
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            dr_q    <= DR_IDLE;
        end else begin
            state_q <= state_d;
            dr_q    <= dr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (rx_data_valid_in) begin
                if      (rx_data_in == WIDTH'(8'hAA)) state_d = WR_ADDR;
                else if (rx_data_in == WIDTH'(8'hBB)) state_d = RD_ADDR;
                else if (rx_data_in == WIDTH'(8'hCC)) state_d = ALU_A;
                else if (rx_data_in == WIDTH'(8'hDD)) state_d = ALU_FUN;
            end
            WR_ADDR:   if (rx_data_valid_in)          state_d = WR_DATA;
            WR_DATA:   if (rx_data_valid_in)          state_d = IDLE;
            RD_ADDR:   if (rx_data_valid_in)          state_d = RD_ISSUE;
            RD_ISSUE:  if (free != '0)                state_d = RD_WAIT;
            RD_WAIT:   if (rf_rd_data_valid_in)       state_d = IDLE;
            ALU_A:     if (rx_data_valid_in)          state_d = ALU_B;
            ALU_B:     if (rx_data_valid_in)          state_d = ALU_FUN;
            ALU_FUN:   if (rx_data_valid_in)          state_d = ALU_ISSUE;
            ALU_ISSUE: if (free >= CW'(RES_BYTES))    state_d = ALU_WAIT;
            ALU_WAIT:  if (alu_data_valid_in)         state_d = IDLE;
            default:                                  state_d = IDLE;
        endcase
        if (tmo_hit) state_d = IDLE;

        // drain waits for busy to rise and fall again, tolerating synchroniser lag
        dr_d = dr_q;
        case (dr_q)
            DR_IDLE: if (pop)         dr_d = DR_HI;
            DR_HI:   if (tx_busy_in)  dr_d = DR_LO;
            DR_LO:   if (!tx_busy_in) dr_d = DR_IDLE;
            default:                  dr_d = DR_IDLE;
        endcase
    end

    always_comb begin
        wr_go      = rx_data_valid_in && (state_q inside {WR_DATA, ALU_A, ALU_B});
        rd_go      = state_q == RD_ISSUE && free != '0;
        alu_go     = state_q == ALU_ISSUE && free >= CW'(RES_BYTES);
        push_n     = '0;
        push_bytes = '0;
        if (state_q == RD_WAIT && rf_rd_data_valid_in) begin
            push_n                = CW'(1);
            push_bytes[WIDTH-1:0] = rf_rd_data_in;
        end
        if (state_q == ALU_WAIT && alu_data_valid_in) begin
            push_n     = CW'(RES_BYTES);
            push_bytes = alu_data_in;
        end
        pop  = dr_q == DR_IDLE && cnt_q != '0 && !tx_busy_in;
        drop = tmo_hit || (rx_data_valid_in &&
               ((state_q == IDLE && !known_cmd) ||
                (state_q inside {RD_ISSUE, RD_WAIT, ALU_ISSUE, ALU_WAIT})));
    end

    // result bytes land least-significant first at consecutive slots
    always_ff @(posedge clk) begin
        for (int i = 0; i < RES_BYTES; i++)
            if (CW'(i) < push_n) mem[wr_ptr_q + PW'(i)] <= push_bytes[i*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rf_wr_en_out <= 1'b0; rf_rd_en_out <= 1'b0; rf_addr_out <= '0; rf_wr_data_out <= '0;
            alu_en_out <= 1'b0; alu_go_q <= 1'b0; alu_fun_out <= '0; clk_gate_en_out <= 1'b0;
            clk_div_en_out <= 1'b0; tx_data_out <= '0; tx_data_valid_out <= 1'b0;
            drop_cnt_out <= '0; wr_ptr_q <= '0; rd_ptr_q <= '0; cnt_q <= '0;
        end else begin
            clk_div_en_out    <= 1'b1;
            rf_wr_en_out      <= wr_go;
            rf_rd_en_out      <= rd_go;
            alu_go_q          <= alu_go;
            alu_en_out        <= alu_go_q;
            tx_data_valid_out <= pop;
            if (alu_go)                                         clk_gate_en_out <= 1'b1;
            else if (state_q == ALU_WAIT && alu_data_valid_in)  clk_gate_en_out <= 1'b0;
            if (rx_data_valid_in) begin
                case (state_q)
                    WR_ADDR, RD_ADDR: rf_addr_out <= rx_data_in[ADDR-1:0];
                    WR_DATA:          rf_wr_data_out <= rx_data_in;
                    ALU_A:   begin rf_addr_out <= ADDR'(0); rf_wr_data_out <= rx_data_in; end
                    ALU_B:   begin rf_addr_out <= ADDR'(1); rf_wr_data_out <= rx_data_in; end
                    ALU_FUN:          alu_fun_out <= rx_data_in[FUN_W-1:0];
                    default: ;
                endcase
            end
            if (pop) tx_data_out <= mem[rd_ptr_q];
            wr_ptr_q <= wr_ptr_q + PW'(push_n);
            rd_ptr_q <= rd_ptr_q + PW'(pop);
            cnt_q    <= cnt_q + push_n - CW'(pop);
            if (drop && drop_cnt_out != 8'hFF) drop_cnt_out <= drop_cnt_out + 8'd1;
        end
    end
endmodule

// File: tb/tb_sys_cmd_controller.sv
// Bench for sys_cmd_controller: directed and random frames against a frame-level reference model.
module tb_sys_cmd_controller;
    localparam int TIMEOUT = 1023;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_data_in;
    logic        rx_data_valid_in;
    logic        tx_busy_in;
    logic [7:0]  rf_rd_data_in = '0;
    logic        rf_rd_data_valid_in = 1'b0;
    logic [15:0] alu_data_in = '0;
    logic        alu_data_valid_in = 1'b0;
    logic        rf_wr_en_out, rf_rd_en_out, alu_en_out, clk_gate_en_out, clk_div_en_out;
    logic        tx_data_valid_out;
    logic [3:0]  rf_addr_out, alu_fun_out;
    logic [7:0]  rf_wr_data_out, tx_data_out, drop_cnt_out;

    logic force_busy = 1'b0, uart_busy = 1'b0;
    assign tx_busy_in = force_busy | uart_busy;

    always #5 clk = ~clk;

    sys_cmd_controller dut (
        .clk(clk), .reset_n(reset_n), .rx_data_in(rx_data_in), .rx_data_valid_in(rx_data_valid_in),
        .tx_busy_in(tx_busy_in), .rf_rd_data_in(rf_rd_data_in), .rf_rd_data_valid_in(rf_rd_data_valid_in),
        .alu_data_in(alu_data_in), .alu_data_valid_in(alu_data_valid_in),
        .rf_wr_en_out(rf_wr_en_out), .rf_rd_en_out(rf_rd_en_out), .rf_addr_out(rf_addr_out),
        .rf_wr_data_out(rf_wr_data_out), .alu_en_out(alu_en_out), .alu_fun_out(alu_fun_out),
        .clk_gate_en_out(clk_gate_en_out), .clk_div_en_out(clk_div_en_out), .tx_data_out(tx_data_out),
        .tx_data_valid_out(tx_data_valid_out), .drop_cnt_out(drop_cnt_out)
    );

    int vectors = 0, errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ALU behaviour of the surrounding system
    function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        case (f % 4)
            0:       return {8'h0, a} + {8'h0, b};
            1:       return {8'h0, a} - {8'h0, b};
            2:       return {8'h0, a} * {8'h0, b};
            default: return {a, b};
        endcase
    endfunction

    // ---------------- environment: register file, ALU, UART TX ----------------
    logic [7:0]  rf_mem [16] = '{default: 8'h00};
    logic [11:0] wr_act [$];
    logic [7:0]  tx_act [$];
    logic [3:0]  fun_act [$];
    int rd_act = 0, hs_bad = 0, gate_bad = 0;
    int rd_dly = 0, alu_dly = 0, u_dly = 0, u_hold = 0;
    logic [7:0]  rd_val = '0;
    logic [15:0] alu_res = '0;
    logic        u_pend = 1'b0;

    always @(negedge clk) begin
        if (rf_wr_en_out) begin
            wr_act.push_back({rf_addr_out, rf_wr_data_out});
            rf_mem[rf_addr_out] = rf_wr_data_out;
        end
        rf_rd_data_valid_in = 1'b0;
        if (rd_dly > 0) begin
            rd_dly--;
            if (rd_dly == 0) begin rf_rd_data_valid_in = 1'b1; rf_rd_data_in = rd_val; end
        end
        if (rf_rd_en_out) begin rd_act++; rd_val = rf_mem[rf_addr_out]; rd_dly = 2; end
    end

    always @(negedge clk) begin
        alu_data_valid_in = 1'b0;
        if (alu_dly > 0) begin
            alu_dly--;
            if (alu_dly == 0) begin alu_data_valid_in = 1'b1; alu_data_in = alu_res; end
        end
        if (alu_en_out) begin
            if (!clk_gate_en_out) gate_bad++;
            fun_act.push_back(alu_fun_out);
            alu_res = alu_fn(rf_mem[0], rf_mem[1], alu_fun_out);
            alu_dly = 3;
        end
    end

    always @(negedge clk) begin
        if (tx_data_valid_out) begin
            tx_act.push_back(tx_data_out);
            if (u_pend) hs_bad++;
            u_pend = 1'b1;
            u_dly  = 2;
        end else if (u_pend) begin
            if (u_dly > 0) begin
                u_dly--;
                if (u_dly == 0) begin uart_busy = 1'b1; u_hold = $urandom_range(2, 5); end
            end else if (u_hold > 0) begin
                u_hold--;
                if (u_hold == 0) begin uart_busy = 1'b0; u_pend = 1'b0; end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  ref_rf [16] = '{default: 8'h00};
    logic [11:0] exp_wr [$];
    logic [7:0]  exp_tx [$];
    logic [3:0]  exp_fun [$];
    int exp_rd = 0, exp_drop = 0;

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); rx_data_in = b; rx_data_valid_in = 1'b1;
        @(negedge clk); rx_data_valid_in = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic frame_wr(input logic [7:0] a, input logic [7:0] d);
        send_byte(8'hAA); send_byte(a); send_byte(d);
        exp_wr.push_back({a[3:0], d});
        ref_rf[a[3:0]] = d;
    endtask

    task automatic frame_rd(input logic [7:0] a);
        send_byte(8'hBB); send_byte(a);
        exp_rd++;
        exp_tx.push_back(ref_rf[a[3:0]]);
    endtask

    task automatic model_alu(input logic [7:0] f);
        logic [15:0] r;
        r = alu_fn(ref_rf[0], ref_rf[1], f[3:0]);
        exp_fun.push_back(f[3:0]);
        exp_tx.push_back(r[7:0]);
        exp_tx.push_back(r[15:8]);
    endtask

    task automatic frame_cc(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
        send_byte(8'hCC); send_byte(a); send_byte(b); send_byte(f);
        exp_wr.push_back({4'd0, a}); exp_wr.push_back({4'd1, b});
        ref_rf[0] = a; ref_rf[1] = b;
        model_alu(f);
    endtask

    task automatic frame_dd(input logic [7:0] f);
        send_byte(8'hDD); send_byte(f);
        model_alu(f);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkpoint(input string tag);
        check({tag, "_wr_count"}, wr_act.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < wr_act.size(); i++) check({tag, "_wr"}, wr_act[i], exp_wr[i]);
        check({tag, "_tx_count"}, tx_act.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < tx_act.size(); i++) check({tag, "_tx"}, tx_act[i], exp_tx[i]);
        check({tag, "_alu_count"}, fun_act.size(), exp_fun.size());
        for (int i = 0; i < exp_fun.size() && i < fun_act.size(); i++) check({tag, "_fun"}, fun_act[i], exp_fun[i]);
        check({tag, "_rd_count"}, rd_act, exp_rd);
        check({tag, "_drop"}, drop_cnt_out, exp_drop);
        check({tag, "_gate_idle"}, clk_gate_en_out, 1'b0);
        check({tag, "_gate_at_alu_en"}, gate_bad, 0);
        check({tag, "_tx_handshake"}, hs_bad, 0);
        wr_act.delete(); exp_wr.delete(); tx_act.delete(); exp_tx.delete(); fun_act.delete(); exp_fun.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        reset_n = 1'b0; rx_data_in = '0; rx_data_valid_in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", {rf_wr_en_out, rf_rd_en_out, rf_addr_out, rf_wr_data_out, alu_en_out, alu_fun_out,
              clk_gate_en_out, clk_div_en_out, tx_data_out, tx_data_valid_out, drop_cnt_out}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("clk_div_en", clk_div_en_out, 1'b1);

        frame_wr(8'h05, 8'h3C); settle(40);
        check("wr_pair", wr_act.size() > 0 ? wr_act[0] : 12'h0, 12'h53C);
        checkpoint("write");
        frame_rd(8'h05); settle(40);
        check("rd_byte", tx_act.size() > 0 ? tx_act[0] : 8'h0, 8'h3C);
        checkpoint("read");
        frame_cc(8'h07, 8'h03, 8'h02); settle(40);
        check("alu_lo", tx_act.size() > 0 ? tx_act[0] : 8'hFF, 8'h15);
        check("alu_hi", tx_act.size() > 1 ? tx_act[1] : 8'hFF, 8'h00);
        checkpoint("alu");

        // unknown command, then reset in the middle of a write frame
        send_byte(8'h55); exp_drop++; settle(5);
        check("unknown_drop", drop_cnt_out, 8'd1);
        send_byte(8'hAA); send_byte(8'h05);
        @(negedge clk); reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midframe_reset_outs", {rf_wr_en_out, rf_rd_en_out, rf_addr_out, rf_wr_data_out, alu_en_out,
              alu_fun_out, clk_gate_en_out, clk_div_en_out, tx_data_out, tx_data_valid_out, drop_cnt_out}, 64'd0);
        reset_n = 1'b1; exp_drop = 0;
        frame_wr(8'h02, 8'h11); settle(40);
        checkpoint("reset");

        // randomized frames, each allowed to complete before the next
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 4))
                0: frame_wr(8'($urandom), 8'($urandom));
                1: frame_rd(8'($urandom));
                2: frame_cc(8'($urandom), 8'($urandom), 8'($urandom));
                3: frame_dd(8'($urandom));
                default: begin
                    do b = 8'($urandom); while (b inside {8'hAA, 8'hBB, 8'hCC, 8'hDD});
                    send_byte(b); exp_drop++;
                end
            endcase
            settle(60);
        end
        checkpoint("random");

        // back-pressure: TX held busy, third ALU op must stall for FIFO space
        force_busy = 1'b1;
        frame_dd(8'h01); settle(15);
        frame_dd(8'h01); settle(15);
        frame_dd(8'h01); settle(5);
        send_byte(8'h12); send_byte(8'h34); exp_drop += 2;
        settle(30);
        check("bp_stalled_ops", fun_act.size(), 2);
        check("bp_no_tx", tx_act.size(), 0);
        check("bp_stall_drops", drop_cnt_out, exp_drop);
        force_busy = 1'b0;
        settle(150);
        checkpoint("backpressure");

`ifdef CMD_TIMEOUT_EN
        send_byte(8'hAA);
        settle(TIMEOUT + 10);
        exp_drop++;
        check("timeout_drop", drop_cnt_out, exp_drop);
        frame_wr(8'h03, 8'h44); settle(40);
        checkpoint("timeout");
`endif

        // drop counter saturates
        for (int n = 0; n < 260; n++) send_byte(8'h00);
        settle(5);
        check("drop_saturate", drop_cnt_out, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
